// File: rtl/menu_pkg.sv
// Shared constants and FSM state type for the menu overlay line fetcher.
package menu_pkg;
  localparam int          COLS      = 32;
  localparam int          ROWS      = 28;
  localparam logic [10:0] FONT_BASE = 11'h400;
  localparam logic [10:0] TEXT_BASE = 11'h000;
  localparam int          LINES     = ROWS * 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHAR  = 2'd1,
    GLYPH = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/menu_linebuf.sv
// Double-banked 32x8 overlay line buffer with per-bank blank flags.
module menu_linebuf (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       ready,
  input  logic       done,
  input  logic       we,
  input  logic [4:0] wa,
  input  logic [7:0] wd,
  input  logic [4:0] ra,
  output logic [7:0] rd_data,
  output logic       rd_blank
);
  logic [7:0] bank [0:1][0:31];
  logic [1:0] blank;
  logic       sel;
  logic       nxt_sel;

  // A line_start flips to the back bank only when that bank holds a finished line.
  assign nxt_sel = (start && ready) ? ~sel : sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      sel   <= 1'b0;
      blank <= 2'b11;
    end else begin
      sel <= nxt_sel;
      if (start && !ready) blank[sel] <= 1'b1;
      // The new back bank shows nothing until a fetch into it completes.
      if (start) blank[~nxt_sel] <= 1'b1;
      if (done) blank[~sel] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (we) bank[~sel][wa] <= wd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data  <= 8'h00;
      rd_blank <= 1'b1;
    end else begin
      rd_data  <= bank[sel][ra];
      rd_blank <= blank[sel];
    end
  end
endmodule

// File: rtl/menu_overlay_fetch.sv
// Fetches one overlay text line (char code then glyph byte per column) from the
// menu RAM into a back bank, and serves pixels from the displayed bank.
module menu_overlay_fetch import menu_pkg::*; #(
  parameter int          COLS      = menu_pkg::COLS,
  parameter int          ROWS      = menu_pkg::ROWS,
  parameter logic [10:0] FONT_BASE = menu_pkg::FONT_BASE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        overlay_en,
  input  logic        line_start,
  input  logic [7:0]  line_y,
  output logic        busy,
  output logic        line_ready,
  output logic [10:0] ram_adb,
  output logic        ram_ceb,
  input  logic [7:0]  ram_doutb,
  input  logic        pix_valid,
  input  logic [7:0]  pix_x,
  output logic        pix_on,
  output logic        pix_on_valid
);
  localparam int         NLINES   = ROWS * 8;
  localparam logic [4:0] LAST_COL = 5'(COLS - 1);

  fetch_state_e state, state_nxt;
  logic [4:0]  col, wr_col;
  logic [7:0]  y_q, code_q;
  logic        cap_pending;
  logic [10:0] adb_hold, adb_nxt;
  logic        line_ok, start_fetch, start_blank, wr_en, last_wr;
  logic [7:0]  rd_data;
  logic        rd_blank;
  logic        valid_q, en_q;
  logic [2:0]  bit_q;

  assign line_ok     = ({1'b0, line_y} < 9'(NLINES));
  assign start_fetch = line_start & line_ok;
  assign start_blank = line_start & ~line_ok;
  // The glyph byte of a column lands while the next column's CHAR read is out.
  assign wr_en       = cap_pending & ~line_start;
  assign last_wr     = wr_en & (wr_col == LAST_COL);
  assign busy        = (state != IDLE) | cap_pending;
  assign ram_adb     = adb_nxt;

  always_comb begin
    state_nxt = state;
    adb_nxt   = adb_hold;
    ram_ceb   = 1'b0;
    case (state)
      CHAR: begin
        ram_ceb   = 1'b1;
        adb_nxt   = TEXT_BASE + {1'b0, y_q[7:3], col};
        state_nxt = GLYPH;
      end
      GLYPH: begin
        ram_ceb   = 1'b1;
        adb_nxt   = FONT_BASE + {1'b0, ram_doutb[6:0], y_q[2:0]};
        state_nxt = (col == LAST_COL) ? IDLE : CHAR;
      end
      default: ;
    endcase
    if (start_fetch)      state_nxt = CHAR;
    else if (start_blank) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      col         <= 5'd0;
      wr_col      <= 5'd0;
      y_q         <= 8'd0;
      code_q      <= 8'd0;
      cap_pending <= 1'b0;
      adb_hold    <= 11'd0;
      line_ready  <= 1'b0;
    end else begin
      state       <= state_nxt;
      adb_hold    <= adb_nxt;
      cap_pending <= (state == GLYPH) & ~line_start;
      if (line_start) y_q <= line_y;
      if (start_fetch) col <= 5'd0;
      else if (state == GLYPH) col <= col + 5'd1;
      if (state == GLYPH) begin
        code_q <= ram_doutb;
        wr_col <= col;
      end
      if (line_start)   line_ready <= start_blank;
      else if (last_wr) line_ready <= 1'b1;
    end
  end

  menu_linebuf u_linebuf (
    .clk      (clk),
    .reset    (reset),
    .start    (line_start),
    .ready    (line_ready),
    .done     (last_wr),
    .we       (wr_en),
    .wa       (wr_col),
    .wd       (ram_doutb ^ {8{code_q[7]}}),
    .ra       (pix_x[7:3]),
    .rd_data  (rd_data),
    .rd_blank (rd_blank)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      en_q    <= 1'b0;
      bit_q   <= 3'd0;
    end else begin
      valid_q <= pix_valid;
      en_q    <= overlay_en;
      bit_q   <= pix_x[2:0];
    end
  end

  assign pix_on       = valid_q & en_q & ~rd_blank & rd_data[bit_q];
  assign pix_on_valid = valid_q;
endmodule
